// File: rtl/riscv_mem_arbiter.sv
// ============================================================================
// riscv_mem_arbiter: shares one single-port SRAM between fetch and LSU,
// LSU priority, one access/cycle, read responses routed back to issuer.
// Optional macro: MEM_ARB_STARVE_GUARD_EN (fetch anti-starvation guard).
// Revision: 1.0
// ============================================================================
`default_nettype none

module riscv_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [DATA_W/8-1:0] lsu_be,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  output logic                lsu_ready,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LSU  = 2'd2
  } owner_e;

  owner_e resp_owner_q, resp_owner_d;
  logic   if_grant;
  logic   lsu_grant;
  logic   force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign force_if = (starve_cnt_q == CNT_MAX);

  // Counts consecutive denied fetch cycles; any fetch grant or idle fetch restarts it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || if_grant) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_MAX) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    if_grant  = 1'b0;
    lsu_grant = 1'b0;
    if (!rst) begin
      if_grant  = if_req && (!lsu_req || force_if);
      lsu_grant = lsu_req && !(if_req && force_if);
    end
  end

  assign if_ready  = if_grant;
  assign lsu_ready = lsu_grant;

  always_comb begin
    mem_en    = if_grant || lsu_grant;
    mem_we    = lsu_grant && lsu_we;
    mem_be    = if_grant ? {(DATA_W/8){1'b1}} : lsu_be;
    mem_addr  = if_grant ? if_addr : lsu_addr;
    mem_wdata = lsu_wdata;
  end

  always_comb begin
    resp_owner_d = OWN_NONE;
    if (if_grant) begin
      resp_owner_d = OWN_IF;
    end else if (lsu_grant && !lsu_we) begin
      resp_owner_d = OWN_LSU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_owner_q <= OWN_NONE;
    end else begin
      resp_owner_q <= resp_owner_d;
    end
  end

  // Responses are also masked while rst is high so an in-flight read vanishes immediately.
  always_comb begin
    if_rvalid  = !rst && (resp_owner_q == OWN_IF);
    lsu_rvalid = !rst && (resp_owner_q == OWN_LSU);
    if_rdata   = if_rvalid  ? mem_rdata : '0;
    lsu_rdata  = lsu_rvalid ? mem_rdata : '0;
  end

endmodule

`default_nettype wire
